// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO onto an asynchronous serial line.
// Watches the FIFO empty flag, issues one-cycle rd strobes and sends each
// byte as start, 8 data bits (LSB first), optional parity, then stop.
// Optional feature: define FIFO_UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit (11-bit frame instead of 10).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] fifo_data,
  output logic       rd,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q,    tx_d;
  logic          rd_q,    rd_d;
  logic          busy_q,  busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par_q,   par_d;
`endif

  logic          bit_end;
  logic [CW-1:0] baud_next;

  // Baud timing: a bit period ends when the counter reaches its last value.
  always_comb begin
    bit_end   = (baud_q == BAUD_LAST);
    baud_next = bit_end ? '0 : baud_q + 1'b1;
  end

  // Next-state logic; tx is precomputed so the pin is driven from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data_out is valid now, one edge after the rd edge.
        shreg_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_data;
`endif
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = baud_next;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        baud_d = baud_next;
        if (bit_end) begin
          // Shift and present the next LSB on the same edge so tx tracks shreg[0].
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        baud_d = baud_next;
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        baud_d = baud_next;
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rd   = rd_q;
  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model upstream, scoreboard of expected
// bytes, and a monitor that decodes every serial frame seen on tx.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int unsigned C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty;
  logic       fifo_empty = 1'b1;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;
  logic [7:0] fifo_dout = '0;
  logic       rd, tx, busy;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_count = 0;
  int busy_cnt = 0;
  int last_rd_cyc = -100;
  int last_fall_cyc = -10000;
  bit prev_complete = 1'b0;
  bit expect_b2b = 1'b0;
  bit in_frame = 1'b0;

  assign empty = force_en ? force_val : fifo_empty;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .fifo_data (fifo_dout),
    .rd        (rd),
    .tx        (tx),
    .busy      (busy)
  );

  // FIFO model: data_out updates on the rd edge, empty tracks occupancy.
  always @(posedge clk) begin
    if (rd && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef FIFO_UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  // Monitor: counts rd/busy, decodes frames and pops the scoreboard.
  initial begin : monitor
    logic        tx_prev;
    int          k;
    logic [10:0] got;
    logic [10:0] expv;
    bit          hold_err;
    logic [7:0]  byte_e;
    tx_prev  = 1'b1;
    k        = 0;
    got      = '0;
    expv     = '0;
    hold_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd) begin
        rd_count++;
        last_rd_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (reset) begin
        in_frame      = 1'b0;
        prev_complete = 1'b0;
      end else if (!in_frame && tx_prev && !tx) begin
        in_frame = 1'b1;
        k        = 0;
        got      = '0;
        hold_err = 1'b0;
        check("start_latency", cyc - last_rd_cyc, 2);
        if (expect_b2b && prev_complete)
          check("b2b_gap", cyc - last_fall_cyc, NB * C + 3);
        last_fall_cyc = cyc;
        check("frame_expected", int'(exp_q.size() > 0), 1);
        byte_e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        expv   = frame_bits(byte_e);
      end
      if (in_frame) begin
        if (k % C == 0) got[4'(k / C)] = tx;
        else if (tx !== got[4'(k / C)]) hold_err = 1'b1;
        k++;
        if (k == NB * C) begin
          check("frame_bits", got, expv);
          check("bit_hold", hold_err, 0);
          in_frame      = 1'b0;
          prev_complete = expect_b2b;
        end
      end
      tx_prev = reset ? 1'b1 : tx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_tx_low(input string name);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 200) begin
      tick(1);
      t++;
    end
    check(name, tx, 0);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy || in_frame) && t < 3000) begin
      tick(1);
      t++;
    end
    check(name, int'(t < 3000), 1);
    tick(3);
  endtask

  initial begin : stimulus
    int r0;
    int b0;
    reset = 1'b1;
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_rd", rd, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("idle_outputs", {tx, rd, busy}, 3'b100);
    end

    // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,(parity 0),1.
    r0 = rd_count;
    b0 = busy_cnt;
    push(8'hA5);
    wait_done("a5_done");
    check("a5_rd_pulses", rd_count - r0, 1);
    check("a5_busy_clocks", busy_cnt - b0, 2 + NB * C);

    // Parity vectors: 0x07 has odd weight, 0x03 even.
    push(8'h07);
    wait_done("p07_done");
    push(8'h03);
    wait_done("p03_done");

    // Back-to-back frames from a preloaded FIFO.
    expect_b2b = 1'b1;
    r0 = rd_count;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_done("b2b_done");
    expect_b2b = 1'b0;
    check("b2b_rd_pulses", rd_count - r0, 3);

    // Empty flag toggling during a frame must not cause extra reads.
    r0 = rd_count;
    push(8'h96);
    wait_tx_low("toggle_start");
    force_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_val = (i % 2 == 0);
      tick(3);
    end
    force_en = 1'b0;
    wait_done("toggle_done");
    tick(20);
    check("toggle_rd_pulses", rd_count - r0, 1);
    check("toggle_idle_busy", busy, 0);

    // Reset during data bit 3 of 0xFF; 0x3C waits in the FIFO.
    push(8'hFF);
    push(8'h3C);
    wait_tx_low("ff_start");
    tick(17);
    reset = 1'b1;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_rd", rd, 0);
    check("midreset_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("inreset_rd", rd, 0);
    end
    reset = 1'b0;
    tick(1);
    check("postreset_rd", rd, 1);
    wait_done("postreset_done");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that sits directly downstream of the 8-deep byte FIFO, on the FIFO read-clock domain. It monitors the FIFO `empty` flag, issues single-cycle `rd` strobes, and captures each returned byte. Each byte is serialized as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. This is the block that drains the FIFO to an external pin.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit period; legal range 2..65535.
- `clk`  input  1  single clock; connected to the FIFO read clock.
- `reset`  input  1  asynchronous, active-high reset.
- `empty`  input  1  FIFO empty flag.
- `fifo_data`  input  8  FIFO `data_out`; valid on the edge after the `rd` edge.
- `rd`  output  1  FIFO read enable; registered one-cycle pulse.
- `tx`  output  1  serial line, registered; idle high.
- `busy`  output  1  high in every state except IDLE; registered.

## Operation
- The FSM has the following states and transitions:
  - IDLE: if `empty`==0 at a clock edge, go to FETCH.
  - FETCH: `rd`=1 for exactly this one cycle, then go to LOAD.
  - LOAD: wait one cycle while the FIFO updates `data_out`. On the exit edge, load `shreg` from `fifo_data`, then go to START.
  - START → DATA (8 bits) → [PARITY] → STOP → IDLE.
- Each of START, DATA-bit, PARITY and STOP lasts exactly `CLKS_PER_BIT` clocks, timed by the baud counter.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It clears on every bit boundary and counts 0..CLKS_PER_BIT-1.
- Bit index is 3 bits, 0..7. DATA exits after bit 7 completes.
- Data is sent LSB first: `tx` = `shreg[0]` and `shreg` shifts right at each DATA bit boundary.
- `rd` is never asserted outside FETCH. Exactly one `rd` pulse is issued per transmitted frame.
- The `empty` flag is sampled only in IDLE. A FIFO going empty mid-frame has no effect on the current frame.
- A byte becoming available during a frame is fetched after STOP completes. There is no pre-fetch.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `rd`=0, `busy`=0, state=IDLE, counters=0, `shreg`=0.
- Latency: edge E0 samples `empty`=0 in IDLE.
  - `rd` is high from E0 to E1.
  - `busy` rises after E0.
  - `fifo_data` is captured at E2.
  - `tx` falls (start bit) after E2.
- Frame length:
  - 10×`CLKS_PER_BIT` clocks from `tx` fall to the end of STOP.
  - 11×`CLKS_PER_BIT` clocks with parity.
- Back-to-back frames: the stop bit is followed by exactly 3 extra high clocks (IDLE, FETCH, LOAD) before the next start bit.
- Reset asserted mid-frame:
  - Outputs return to reset values immediately (asynchronous reset).
  - The in-flight byte is lost; it has already been popped.
  - No `rd` is issued until reset deasserts and `empty`=0 is sampled.
- Reset deasserted with `empty`=0: the first `rd` occurs after the first clock edge at which reset is low.
- `CLKS_PER_BIT`=2: bit periods are 2 clocks; no other behaviour changes.

## Configuration
- Macro `FIFO_UART_TX_PARITY_EN` controls the parity bit.
- When defined:
  - A PARITY state follows DATA, sending even parity (XOR of the 8 data bits).
  - The frame is 11 bits.
- When undefined:
  - The PARITY state and parity logic are absent; DATA goes directly to STOP.
  - The frame is 10 bits.

## Test plan
- **Reset idle:** assert `reset` with `empty`=1 → `tx`=1, `rd`=0, `busy`=0, held for 100 clocks after reset release.
- **Single byte, `CLKS_PER_BIT`=4:**
  - Stimulus: `empty`=0 for one sample; `fifo_data`=8'hA5 on the edge after `rd`.
  - Response: one `rd` pulse; `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks; `busy` high 2+40 clocks.
- **Parity (macro defined):** byte 8'h07 → parity bit 1; byte 8'h03 → parity bit 0; frames are 44 clocks at `CLKS_PER_BIT`=4.
- **Back-to-back:**
  - Stimulus: FIFO preloaded with 8'h01, 8'h02, 8'h03.
  - Response: exactly 3 `rd` pulses; stop-bit high time between frames is `CLKS_PER_BIT`+3 clocks; bytes arrive in order.
- **Reset mid-frame:**
  - Stimulus: assert `reset` during DATA bit 3 of 8'hFF.
  - Response: `tx`=1 in the same cycle. After release with `empty`=0, the next frame starts with a fresh `rd`, and its start bit begins 2 clocks after the first sampling edge.
- **Empty toggling mid-frame:** `empty` pulses high/low during a frame → no extra `rd`; the frame completes unchanged.
